// File: rtl/regbank_wr_arbiter_pkg.sv
// rtl/regbank_wr_arbiter_pkg.sv - shared state encoding and parameter defaults for the write arbiter
package regbank_wr_arbiter_pkg;

  localparam int NREG_DEFAULT = 8;
  localparam int AW_DEFAULT   = 3;
  localparam int DW_DEFAULT   = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR      = 2'd1,
    ST_CLR_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/regbank_wr_arbiter_rr_arb2.sv
// rtl/regbank_wr_arbiter_rr_arb2.sv - two-way round-robin arbiter holding the last-grant pointer
module regbank_wr_arbiter_rr_arb2 (
  input  logic clk,
  input  logic clr,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant0,
  output logic grant1
);

  // 1 means requester 1 won the most recent accepted transfer
  logic last1;

  // Pointer moves only when the granted transfer is actually accepted
  always_ff @(posedge clk) begin
    if (clr) begin
      last1 <= 1'b1;
    end else if (advance) begin
      last1 <= grant1;
    end
  end

  // On conflict the requester that did not win last time is favoured
  always_comb begin
    grant0 = valid0 && (!valid1 || last1);
    grant1 = valid1 && (!valid0 || !last1);
  end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// rtl/regbank_wr_arbiter.sv - shares register-bank write port between two requesters, with bank clear
module regbank_wr_arbiter
  import regbank_wr_arbiter_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            bank_clr_req,
  output logic            bank_clr_done,
  output logic [NREG-1:0] reg_load,
  output logic [DW-1:0]   reg_d,
  output logic            reg_clr,
  output logic            wr_err
);

  state_t          state_q;
  state_t          state_d;
  logic            arb_en;
  logic            clr_start;
  logic            grant0;
  logic            grant1;
  logic            advance;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NREG-1:0] load_dec;
  logic            addr_ok;

  regbank_wr_arbiter_rr_arb2 u_arb (
    .clk     (clk),
    .clr     (clr),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .advance (advance),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  // Clear-sequencer state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear sequencing; arbitration is only open in IDLE with no clear pending
  always_comb begin
    state_d   = state_q;
    arb_en    = 1'b0;
    clr_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bank_clr_req) begin
          state_d   = ST_CLR;
          clr_start = 1'b1;
        end else begin
          arb_en = 1'b1;
        end
      end
      ST_CLR: begin
        state_d = bank_clr_req ? ST_CLR_WAIT : ST_IDLE;
      end
      ST_CLR_WAIT: begin
        if (!bank_clr_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req0_ready = arb_en && grant0;
  assign req1_ready = arb_en && grant1;
  assign advance    = req0_ready || req1_ready;

  // Select the accepted request and decode its address into a load strobe
  always_comb begin
    sel_addr = req1_ready ? req1_addr : req0_addr;
    sel_data = req1_ready ? req1_data : req0_data;
    addr_ok  = 32'(sel_addr) < NREG;
    load_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel_addr == AW'(i)) begin
        load_dec[i] = 1'b1;
      end
    end
  end

  // Output registers: strobes live for exactly the cycle after the handshake
  always_ff @(posedge clk) begin
    if (clr) begin
      reg_load      <= '0;
      reg_d         <= '0;
      reg_clr       <= 1'b0;
      bank_clr_done <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      reg_clr       <= clr_start;
      bank_clr_done <= clr_start;
      if (advance) begin
        reg_load <= load_dec;
        reg_d    <= sel_data;
        wr_err   <= !addr_ok;
      end else begin
        reg_load <= '0;
        wr_err   <= 1'b0;
      end
    end
  end

endmodule
